// File: rtl/rcc_pkg.sv
// rtl/rcc_pkg.sv - shared types and constants for the ripple-counter sequence checker
//
// Purpose: FSM state encoding, default monitored width and step-classification
//          codes used by rcc_sequence_checker.
// Ports:   none (package)
package rcc_pkg;

  localparam int RCC_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_RESYNC  = 2'd3
  } rcc_state_t;

  typedef enum logic [1:0] {
    STEP_LEGAL   = 2'd0,
    STEP_WRAP    = 2'd1,
    STEP_RESTART = 2'd2,
    STEP_ILLEGAL = 2'd3
  } rcc_step_t;

endpackage

// File: rtl/rcc_sat_counter.sv
// rtl/rcc_sat_counter.sv - saturating event counter
//
// Purpose: counts increment requests and holds at all-ones instead of wrapping.
// Ports:
//   i_clk    - clock, rising edge
//   i_reset  - synchronous active-low reset, clears the count
//   i_inc    - increment request for this cycle
//   o_count  - current count [W-1:0]
module rcc_sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/rcc_sequence_checker.sv
// rtl/rcc_sequence_checker.sv - monitor checking that a counter advances by +1 each cycle
//
// Purpose: samples the upstream count every cycle, flags wraps, upstream
//          restarts and illegal steps, and keeps saturating statistics.
// Ports:
//   clk           - clock, rising edge
//   reset         - synchronous active-low reset
//   enable        - checking enable; low returns the FSM to IDLE
//   q_in          - sampled upstream count [WIDTH-1:0]
//   locked        - high while in TRACK
//   wrap_pulse    - one-cycle pulse on a legal max->0 step in TRACK
//   restart_pulse - one-cycle pulse on a 0 sample after a non-max value
//   step_err      - one-cycle pulse on an illegal step
//   err_sticky    - latched step_err, cleared only by reset
//   wrap_count    - saturating count of wrap_pulse [STAT_W-1:0]
//   err_count     - saturating count of step_err [STAT_W-1:0]
//   state_o       - current FSM state encoding
module rcc_sequence_checker
  import rcc_pkg::*;
#(
  parameter int WIDTH    = RCC_WIDTH_DEFAULT,
  parameter int STAT_W   = 8,
  parameter int LOCK_RUN = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [WIDTH-1:0]  q_in,
  output logic              locked,
  output logic              wrap_pulse,
  output logic              restart_pulse,
  output logic              step_err,
  output logic              err_sticky,
  output logic [STAT_W-1:0] wrap_count,
  output logic [STAT_W-1:0] err_count,
  output logic [1:0]        state_o
);

  // run counter wraps back to TRACK when it would reach LOCK_RUN
  localparam logic [3:0] RUN_LAST = 4'(LOCK_RUN - 1);

  rcc_state_t       r_state;
  logic [WIDTH-1:0] r_prev;
  logic [3:0]       r_run;
  logic             r_wrap_pulse;
  logic             r_restart_pulse;
  logic             r_step_err;
  logic             r_err_sticky;

  logic [WIDTH-1:0] w_expect;
  rcc_step_t        w_step;
  logic             w_wrap_inc;
  logic             w_err_inc;

  // A legal wrap (max->0) matches the +1 test first, so the restart branch
  // only ever sees a zero that followed a non-max value.
  always_comb begin
    w_expect = r_prev + WIDTH'(1);
    w_step   = STEP_ILLEGAL;
    if (q_in == w_expect) begin
      w_step = (r_prev == {WIDTH{1'b1}}) ? STEP_WRAP : STEP_LEGAL;
    end else if (q_in == '0) begin
      w_step = STEP_RESTART;
    end
  end

  // Statistics update on the same edge as the matching pulse.
  assign w_wrap_inc = reset && enable && (r_state == ST_TRACK) && (w_step == STEP_WRAP);
  assign w_err_inc  = reset && enable && ((r_state == ST_TRACK) || (r_state == ST_RESYNC))
                      && (w_step == STEP_ILLEGAL);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_prev          <= '0;
      r_run           <= '0;
      r_wrap_pulse    <= 1'b0;
      r_restart_pulse <= 1'b0;
      r_step_err      <= 1'b0;
      r_err_sticky    <= 1'b0;
    end else begin
      r_wrap_pulse    <= 1'b0;
      r_restart_pulse <= 1'b0;
      r_step_err      <= 1'b0;
      if (!enable) begin
        r_state <= ST_IDLE;
        r_run   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_ACQUIRE;
          end
          ST_ACQUIRE: begin
            r_prev  <= q_in;
            r_state <= ST_TRACK;
          end
          ST_TRACK: begin
            r_prev <= q_in;
            case (w_step)
              STEP_WRAP:    r_wrap_pulse    <= 1'b1;
              STEP_RESTART: r_restart_pulse <= 1'b1;
              STEP_ILLEGAL: begin
                r_step_err   <= 1'b1;
                r_err_sticky <= 1'b1;
                r_state      <= ST_RESYNC;
                r_run        <= '0;
              end
              default: ;
            endcase
          end
          ST_RESYNC: begin
            r_prev <= q_in;
            case (w_step)
              STEP_LEGAL, STEP_WRAP: begin
                if (r_run == RUN_LAST) begin
                  r_state <= ST_TRACK;
                  r_run   <= '0;
                end else begin
                  r_run <= r_run + 4'd1;
                end
              end
              STEP_RESTART: begin
                r_restart_pulse <= 1'b1;
                r_run           <= '0;
              end
              default: begin
                r_step_err   <= 1'b1;
                r_err_sticky <= 1'b1;
                r_run        <= '0;
              end
            endcase
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  rcc_sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_inc   (w_wrap_inc),
    .o_count (wrap_count)
  );

  rcc_sat_counter #(.W(STAT_W)) u_err_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_inc   (w_err_inc),
    .o_count (err_count)
  );

  assign locked        = (r_state == ST_TRACK);
  assign wrap_pulse    = r_wrap_pulse;
  assign restart_pulse = r_restart_pulse;
  assign step_err      = r_step_err;
  assign err_sticky    = r_err_sticky;
  assign state_o       = r_state;

endmodule

// File: tb/tb_rcc_sequence_checker.sv
// tb/tb_rcc_sequence_checker.sv - directed vector bench for rcc_sequence_checker
module tb_rcc_sequence_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] q_in;

  logic       locked, wrap_pulse, restart_pulse, step_err, err_sticky;
  logic [7:0] wrap_count, err_count;
  logic [1:0] state_o;

  logic       s_locked, s_wrap_pulse, s_restart_pulse, s_step_err, s_err_sticky;
  logic [1:0] s_wrap_count, s_err_count;
  logic [1:0] s_state_o;

  always #5 clk = ~clk;

  rcc_sequence_checker #(.WIDTH(4), .STAT_W(8), .LOCK_RUN(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .q_in(q_in),
    .locked(locked), .wrap_pulse(wrap_pulse), .restart_pulse(restart_pulse),
    .step_err(step_err), .err_sticky(err_sticky), .wrap_count(wrap_count),
    .err_count(err_count), .state_o(state_o)
  );

  rcc_sequence_checker #(.WIDTH(4), .STAT_W(2), .LOCK_RUN(3)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .q_in(q_in),
    .locked(s_locked), .wrap_pulse(s_wrap_pulse), .restart_pulse(s_restart_pulse),
    .step_err(s_step_err), .err_sticky(s_err_sticky), .wrap_count(s_wrap_count),
    .err_count(s_err_count), .state_o(s_state_o)
  );

  // {state, locked, wrap, restart, err, sticky, wrap_count, err_count, sat err_count}
  logic [24:0] act;
  assign act = {state_o, locked, wrap_pulse, restart_pulse, step_err, err_sticky,
                wrap_count, err_count, s_err_count};

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [3:0]  q;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic logic [24:0] pack(input logic [1:0] st, input logic wp, input logic rp,
                                       input logic se, input logic sticky,
                                       input logic [7:0] wc, input logic [7:0] ec);
    logic [1:0] sec;
    sec = (ec > 8'd3) ? 2'd3 : ec[1:0];
    return {st, (st == 2'd2), wp, rp, se, sticky, wc, ec, sec};
  endfunction

  function automatic void add(input logic r, input logic e, input int q,
                              input logic [1:0] st, input logic wp, input logic rp,
                              input logic se, input logic sticky,
                              input logic [7:0] wc, input logic [7:0] ec);
    vec_t v;
    v.rst_n = r;
    v.en    = e;
    v.q     = 4'(q);
    v.exp   = pack(st, wp, rp, se, sticky, wc, ec);
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic e, input int q);
    @(negedge clk);
    reset  = r;
    enable = e;
    q_in   = 4'(q);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [24:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    q_in   = 4'd0;

    // reset, acquire, free run 0..15,0,1
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 15; i++) add(1, 1, i, 2, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 2, 1, 0, 0, 0, 1, 0);
    add(1, 1, 1, 2, 0, 0, 0, 0, 1, 0);
    // upstream restart 7,8,0,1
    for (int i = 2; i <= 8; i++) add(1, 1, i, 2, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 2, 0, 1, 0, 0, 1, 0);
    add(1, 1, 1, 2, 0, 0, 0, 0, 1, 0);
    // glitch 3,4,6,7,8,9
    for (int i = 2; i <= 4; i++) add(1, 1, i, 2, 0, 0, 0, 0, 1, 0);
    add(1, 1, 6, 3, 0, 0, 1, 1, 1, 1);
    add(1, 1, 7, 3, 0, 0, 0, 1, 1, 1);
    add(1, 1, 8, 3, 0, 0, 0, 1, 1, 1);
    add(1, 1, 9, 2, 0, 0, 0, 1, 1, 1);
    // error during resync 3,5,6,6,7,8,9
    add(1, 1, 0, 2, 0, 1, 0, 1, 1, 1);
    for (int i = 1; i <= 3; i++) add(1, 1, i, 2, 0, 0, 0, 1, 1, 1);
    add(1, 1, 5, 3, 0, 0, 1, 1, 1, 2);
    add(1, 1, 6, 3, 0, 0, 0, 1, 1, 2);
    add(1, 1, 6, 3, 0, 0, 1, 1, 1, 3);
    add(1, 1, 7, 3, 0, 0, 0, 1, 1, 3);
    add(1, 1, 8, 3, 0, 0, 0, 1, 1, 3);
    add(1, 1, 9, 2, 0, 0, 0, 1, 1, 3);
    // more glitches: STAT_W=2 instance holds at 3
    add(1, 1, 11, 3, 0, 0, 1, 1, 1, 4);
    add(1, 1, 13, 3, 0, 0, 1, 1, 1, 5);
    // enable low: IDLE, stats kept, no pulses
    add(1, 0, 14, 0, 0, 0, 0, 1, 1, 5);
    add(1, 0, 3, 0, 0, 0, 0, 1, 1, 5);
    add(1, 1, 5, 1, 0, 0, 0, 1, 1, 5);
    add(1, 1, 6, 2, 0, 0, 0, 1, 1, 5);
    add(1, 1, 7, 2, 0, 0, 0, 1, 1, 5);
    // into RESYNC, then reset mid-operation and re-acquire
    add(1, 1, 9, 3, 0, 0, 1, 1, 1, 6);
    add(1, 1, 10, 3, 0, 0, 0, 1, 1, 6);
    add(0, 1, 11, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 12, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 13, 2, 0, 0, 0, 0, 0, 0);
    add(1, 1, 14, 2, 0, 0, 0, 0, 0, 0);
    add(1, 1, 15, 2, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 2, 1, 0, 0, 0, 1, 0);
    add(1, 1, 1, 2, 0, 0, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].en, int'(vecs[i].q));
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // wrap inside RESYNC counts as a legal step but raises no wrap_pulse
    drive(1, 1, 13); check("resync_enter", pack(3, 0, 0, 1, 1, 1, 1));
    drive(1, 1, 14); check("resync_run1", pack(3, 0, 0, 0, 1, 1, 1));
    drive(1, 1, 15); check("resync_run2", pack(3, 0, 0, 0, 1, 1, 1));
    drive(1, 1, 0);  check("resync_wrap_no_pulse", pack(2, 0, 0, 0, 1, 1, 1));

    // restart inside RESYNC clears the run
    drive(1, 1, 5);  check("resync_err2", pack(3, 0, 0, 1, 1, 1, 2));
    drive(1, 1, 6);  check("resync_run_a", pack(3, 0, 0, 0, 1, 1, 2));
    drive(1, 1, 0);  check("resync_restart", pack(3, 0, 1, 0, 1, 1, 2));
    drive(1, 1, 1);  check("run_cleared", pack(3, 0, 0, 0, 1, 1, 2));
    drive(1, 1, 2);  check("run_two", pack(3, 0, 0, 0, 1, 1, 2));
    drive(1, 1, 3);  check("relock", pack(2, 0, 0, 0, 1, 1, 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
